// File: rtl/bt_cmd_parser.sv
// bt_cmd_parser: frames UART bytes into HDR/CMD/VAL/CHK commands.
//   Frame = 8'hA5, CMD, VAL, CHK with CHK = (CMD + VAL) mod 256.
//   Optional inter-byte timeout is built only when BT_TIMEOUT_EN is defined.
// Ports:
//   Clk       system clock, rising edge
//   Rst       asynchronous active-high reset
//   RxData    received byte, qualified by RxDone
//   RxDone    one-cycle strobe per received byte
//   Cmd       command byte of last accepted frame (held)
//   Value     value byte of last accepted frame (held)
//   CmdValid  one-cycle pulse per accepted frame
//   Busy      registered, high while a frame is partially received
//   ErrCnt    saturating count of rejected frames (bad CHK or timeout)
module bt_cmd_parser #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] RxData,
    input  logic       RxDone,
    output logic [7:0] Cmd,
    output logic [7:0] Value,
    output logic       CmdValid,
    output logic       Busy,
    output logic [7:0] ErrCnt
);
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 24;
    localparam logic [DW-1:0] HDR     = 8'hA5;
    localparam logic [DW-1:0] ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_HDR = 2'd1,
        GOT_CMD = 2'd2,
        GOT_VAL = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] cmd_q;
    logic [DW-1:0] val_q;
    logic [DW-1:0] cmd_nx;
    logic [DW-1:0] val_nx;
    logic [DW-1:0] cmd_out_nx;
    logic [DW-1:0] value_out_nx;
    logic [DW-1:0] err_nx;
    logic          valid_nx;
    logic          busy_nx;
    logic          err_inc_c;
    logic          chk_ok_c;
    logic          timeout_c;

    // Checksum of the frame being assembled, 8-bit wrap.
    assign chk_ok_c = (RxData == DW'(cmd_q + val_q));

`ifdef BT_TIMEOUT_EN
    logic [TW-1:0] timer_q;

    // Inter-byte timer: idles at zero in IDLE, restarts on every byte.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            timer_q <= '0;
        end else if (RxDone || (state == IDLE) || timeout_c) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_c = (state != IDLE) && !RxDone
                       && (timer_q == (TIMEOUT_CYCLES - TW'(1)));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_c          = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            cmd_q    <= '0;
            val_q    <= '0;
            Cmd      <= '0;
            Value    <= '0;
            CmdValid <= 1'b0;
            Busy     <= 1'b0;
            ErrCnt   <= '0;
        end else begin
            state    <= state_nx;
            cmd_q    <= cmd_nx;
            val_q    <= val_nx;
            Cmd      <= cmd_out_nx;
            Value    <= value_out_nx;
            CmdValid <= valid_nx;
            Busy     <= busy_nx;
            ErrCnt   <= err_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        cmd_nx       = cmd_q;
        val_nx       = val_q;
        cmd_out_nx   = Cmd;
        value_out_nx = Value;
        valid_nx     = 1'b0;
        err_inc_c    = 1'b0;

        if (RxDone) begin
            unique case (state)
                IDLE: begin
                    // Non-header bytes are line noise, not errors.
                    if (RxData == HDR) begin
                        state_nx = GOT_HDR;
                    end
                end
                GOT_HDR: begin
                    cmd_nx   = RxData;
                    state_nx = GOT_CMD;
                end
                GOT_CMD: begin
                    val_nx   = RxData;
                    state_nx = GOT_VAL;
                end
                GOT_VAL: begin
                    // A bad CHK never restarts a frame, even if it is 8'hA5.
                    if (chk_ok_c) begin
                        cmd_out_nx   = cmd_q;
                        value_out_nx = val_q;
                        valid_nx     = 1'b1;
                    end else begin
                        err_inc_c = 1'b1;
                    end
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout_c) begin
            state_nx  = IDLE;
            err_inc_c = 1'b1;
        end

        err_nx  = (err_inc_c && (ErrCnt != ERR_MAX)) ? (ErrCnt + DW'(1)) : ErrCnt;
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Testbench for bt_cmd_parser (TIMEOUT_CYCLES overridden to 100).
module tb_bt_cmd_parser;
    localparam int TO = 100;

    logic       Clk;
    logic       Rst;
    logic [7:0] RxData;
    logic       RxDone;
    logic [7:0] Cmd;
    logic [7:0] Value;
    logic       CmdValid;
    logic       Busy;
    logic [7:0] ErrCnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes of the frame collected so far.
    logic [7:0] mq[$];
    logic [7:0] m_cmd;
    logic [7:0] m_val;
    logic [7:0] m_err;
    logic       m_valid;
    logic       m_busy;
    int         m_idle;

    bt_cmd_parser #(.TIMEOUT_CYCLES(24'd100)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .Cmd      (Cmd),
        .Value    (Value),
        .CmdValid (CmdValid),
        .Busy     (Busy),
        .ErrCnt   (ErrCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq.delete();
        m_cmd   = 8'h00;
        m_val   = 8'h00;
        m_err   = 8'h00;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_idle  = 0;
    endtask

    task automatic model_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Expected outputs after the coming rising edge.
    task automatic model_step(input logic done, input logic [7:0] data);
        m_valid = 1'b0;
        if (done) begin
            m_idle = 0;
            if (mq.size() == 0) begin
                if (data == 8'hA5) mq.push_back(data);
            end else begin
                mq.push_back(data);
                if (mq.size() == 4) begin
                    if (8'(mq[1] + mq[2]) == mq[3]) begin
                        m_cmd   = mq[1];
                        m_val   = mq[2];
                        m_valid = 1'b1;
                    end else begin
                        model_err();
                    end
                    mq.delete();
                end
            end
        end else if (mq.size() != 0) begin
`ifdef BT_TIMEOUT_EN
            m_idle++;
            if (m_idle >= TO) begin
                mq.delete();
                model_err();
                m_idle = 0;
            end
`endif
        end
        m_busy = (mq.size() != 0);
    endtask

    task automatic cycle(input logic done, input logic [7:0] data);
        RxDone = done;
        RxData = data;
        model_step(done, data);
        @(posedge Clk);
        #1;
        RxDone = 1'b0;
        RxData = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        RxDone = 1'b0;
        RxData = 8'h00;
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        RxDone = 1'b0;
        RxData = 8'h00;
        model_reset();
        @(posedge Clk);
        #1;
        checks++; if (Cmd !== 8'h00) begin failures++; $display("FAIL reset_cmd: got %h want 00", Cmd); end
        checks++; if (Value !== 8'h00) begin failures++; $display("FAIL reset_value: got %h want 00", Value); end
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", CmdValid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (ErrCnt !== 8'h00) begin failures++; $display("FAIL reset_errcnt: got %h want 00", ErrCnt); end
        Rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        do_reset();
        send(8'hA5); send(8'h03); send(8'h10);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL basic_busy_mid: got %b want 1", Busy); end
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL basic_valid_early: got %b want 0", CmdValid); end
        send(8'h13);
        checks++; if (CmdValid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", CmdValid); end
        checks++; if (Cmd !== 8'h03) begin failures++; $display("FAIL basic_cmd: got %h want 03", Cmd); end
        checks++; if (Value !== 8'h10) begin failures++; $display("FAIL basic_value: got %h want 10", Value); end
        checks++; if (ErrCnt !== 8'h00) begin failures++; $display("FAIL basic_errcnt: got %h want 00", ErrCnt); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b want 0", Busy); end
        idle(1);
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width: got %b want 0", CmdValid); end
        checks++; if (Cmd !== 8'h03) begin failures++; $display("FAIL basic_cmd_hold: got %h want 03", Cmd); end
    endtask

    task automatic test_wrap_and_bad_chk();
        send(8'hA5); send(8'hFF); send(8'h02); send(8'h01);
        checks++; if (CmdValid !== 1'b1) begin failures++; $display("FAIL wrap_valid: got %b want 1", CmdValid); end
        checks++; if (Cmd !== 8'hFF) begin failures++; $display("FAIL wrap_cmd: got %h want FF", Cmd); end
        checks++; if (Value !== 8'h02) begin failures++; $display("FAIL wrap_value: got %h want 02", Value); end
        send(8'hA5); send(8'h01); send(8'h01); send(8'h05);
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL badchk_valid: got %b want 0", CmdValid); end
        checks++; if (Cmd !== 8'hFF) begin failures++; $display("FAIL badchk_cmd: got %h want FF", Cmd); end
        checks++; if (Value !== 8'h02) begin failures++; $display("FAIL badchk_value: got %h want 02", Value); end
        checks++; if (ErrCnt !== 8'h01) begin failures++; $display("FAIL badchk_errcnt: got %h want 01", ErrCnt); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL badchk_busy: got %b want 0", Busy); end
    endtask

    task automatic test_noise();
        send(8'h00); send(8'h5A); send(8'hFF);
        checks++; if (ErrCnt !== 8'h01) begin failures++; $display("FAIL noise_errcnt: got %h want 01", ErrCnt); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL noise_busy: got %b want 0", Busy); end
        send(8'hA5); send(8'hA5); send(8'h00); send(8'hA5);
        checks++; if (CmdValid !== 1'b1) begin failures++; $display("FAIL hdrcmd_valid: got %b want 1", CmdValid); end
        checks++; if (Cmd !== 8'hA5) begin failures++; $display("FAIL hdrcmd_cmd: got %h want A5", Cmd); end
        checks++; if (Value !== 8'h00) begin failures++; $display("FAIL hdrcmd_value: got %h want 00", Value); end
        // Bad CHK equal to A5 must not open a frame.
        send(8'hA5); send(8'h01); send(8'h01); send(8'hA5);
        checks++; if (ErrCnt !== 8'h02) begin failures++; $display("FAIL a5chk_errcnt: got %h want 02", ErrCnt); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL a5chk_busy: got %b want 0", Busy); end
        send(8'h01); send(8'h01); send(8'h02);
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL a5chk_no_frame: got %b want 0", CmdValid); end
        checks++; if (Cmd !== 8'hA5) begin failures++; $display("FAIL a5chk_cmd_hold: got %h want A5", Cmd); end
    endtask

    task automatic test_timeout();
        logic exp_busy;
        logic [7:0] exp_err;
        do_reset();
        send(8'hA5); send(8'h07);
        for (int i = 0; i < 150; i++) begin
            cycle(1'b0, 8'h00);
`ifdef BT_TIMEOUT_EN
            exp_busy = ((i + 1) < TO);
`else
            exp_busy = 1'b1;
`endif
            checks++; if (Busy !== exp_busy) begin failures++; $display("FAIL timeout_busy idle=%0d: got %b want %b", i + 1, Busy, exp_busy); end
        end
`ifdef BT_TIMEOUT_EN
        exp_err = 8'h01;
`else
        exp_err = 8'h00;
`endif
        checks++; if (ErrCnt !== exp_err) begin failures++; $display("FAIL timeout_errcnt: got %h want %h", ErrCnt, exp_err); end
`ifdef BT_TIMEOUT_EN
        send(8'hA5); send(8'h07); send(8'h01); send(8'h08);
        checks++; if (CmdValid !== 1'b1) begin failures++; $display("FAIL after_to_valid: got %b want 1", CmdValid); end
        checks++; if (Cmd !== 8'h07) begin failures++; $display("FAIL after_to_cmd: got %h want 07", Cmd); end
        checks++; if (Value !== 8'h01) begin failures++; $display("FAIL after_to_value: got %h want 01", Value); end
        checks++; if (ErrCnt !== 8'h01) begin failures++; $display("FAIL after_to_errcnt: got %h want 01", ErrCnt); end
`else
        // Stale frame A5,07 completes with VAL=A5, CHK=07: bad checksum.
        send(8'hA5); send(8'h07);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL stale_busy: got %b want 0", Busy); end
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL stale_valid: got %b want 0", CmdValid); end
        checks++; if (ErrCnt !== 8'h01) begin failures++; $display("FAIL stale_errcnt: got %h want 01", ErrCnt); end
        send(8'h01); send(8'h08);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL stale_tail_busy: got %b want 0", Busy); end
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL stale_tail_valid: got %b want 0", CmdValid); end
`endif
    endtask

    task automatic test_timeout_edges();
        logic       exp_busy;
        logic [7:0] exp_err;
        // Byte lands exactly on the expiry cycle: byte wins.
        do_reset();
        send(8'hA5); send(8'h07);
        idle(TO - 1);
        send(8'h01);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL edge_busy: got %b want 1", Busy); end
        checks++; if (ErrCnt !== 8'h00) begin failures++; $display("FAIL edge_errcnt: got %h want 00", ErrCnt); end
        send(8'h08);
        checks++; if (CmdValid !== 1'b1) begin failures++; $display("FAIL edge_valid: got %b want 1", CmdValid); end
        checks++; if (Value !== 8'h01) begin failures++; $display("FAIL edge_value: got %h want 01", Value); end
        // One cycle later the timeout has already fired.
        do_reset();
        send(8'hA5); send(8'h07);
        idle(TO);
        send(8'h01);
`ifdef BT_TIMEOUT_EN
        exp_busy = 1'b0;
        exp_err  = 8'h01;
`else
        exp_busy = 1'b1;
        exp_err  = 8'h00;
`endif
        checks++; if (Busy !== exp_busy) begin failures++; $display("FAIL late_busy: got %b want %b", Busy, exp_busy); end
        checks++; if (ErrCnt !== exp_err) begin failures++; $display("FAIL late_errcnt: got %h want %h", ErrCnt, exp_err); end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  stim[$];
        logic [7:0]  c;
        logic [7:0]  v;
        logic [7:0]  chk;
        logic [7:0]  d;
        int unsigned kind;
        int          good;
        int          bad;
        int          pulses;
        good = 0; bad = 0; pulses = 0;
        do_reset();
        for (int f = 0; f < 80; f++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                d = 8'($urandom);
                if (d == 8'hA5) d = 8'h00;
                stim.push_back({1'b1, d});
            end else begin
                c = 8'($urandom);
                v = 8'($urandom);
                if (kind == 2) begin
                    chk = 8'(c + v + 8'($urandom_range(1, 255)));
                    bad++;
                end else begin
                    chk = 8'(c + v);
                    good++;
                end
                stim.push_back({1'b1, 8'hA5});
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) stim.push_back(9'h000);
                stim.push_back({1'b1, c});
                stim.push_back({1'b1, v});
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) stim.push_back(9'h000);
                stim.push_back({1'b1, chk});
            end
            if ($urandom_range(0, 1) == 1) stim.push_back(9'h000);
        end
        stim.push_back(9'h000);
        foreach (stim[i]) begin
            cycle(stim[i][8], stim[i][7:0]);
            if (CmdValid === 1'b1) pulses++;
            checks++; if (CmdValid !== m_valid) begin failures++; $display("FAIL b2b_valid step=%0d: got %b want %b", i, CmdValid, m_valid); end
            checks++; if (Busy !== m_busy) begin failures++; $display("FAIL b2b_busy step=%0d: got %b want %b", i, Busy, m_busy); end
            checks++; if (Cmd !== m_cmd) begin failures++; $display("FAIL b2b_cmd step=%0d: got %h want %h", i, Cmd, m_cmd); end
            checks++; if (Value !== m_val) begin failures++; $display("FAIL b2b_value step=%0d: got %h want %h", i, Value, m_val); end
            checks++; if (ErrCnt !== m_err) begin failures++; $display("FAIL b2b_errcnt step=%0d: got %h want %h", i, ErrCnt, m_err); end
        end
        checks++; if (pulses != good) begin failures++; $display("FAIL b2b_pulse_count: got %0d want %0d", pulses, good); end
        checks++; if (ErrCnt !== 8'(bad)) begin failures++; $display("FAIL b2b_err_total: got %h want %h", ErrCnt, 8'(bad)); end
    endtask

    task automatic test_reset_mid_and_saturate();
        do_reset();
        send(8'hA5); send(8'h02);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", Busy); end
        // Async reset: no clock edge between assert and check.
        Rst = 1'b1;
        model_reset();
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b want 0", Busy); end
        checks++; if (ErrCnt !== 8'h00) begin failures++; $display("FAIL mid_rst_errcnt: got %h want 00", ErrCnt); end
        checks++; if (Cmd !== 8'h00) begin failures++; $display("FAIL mid_rst_cmd: got %h want 00", Cmd); end
        checks++; if (Value !== 8'h00) begin failures++; $display("FAIL mid_rst_value: got %h want 00", Value); end
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", CmdValid); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            send(8'hA5); send(8'h01); send(8'h01); send(8'h00);
            if (n == 0) begin
                checks++; if (ErrCnt !== 8'h01) begin failures++; $display("FAIL sat_first: got %h want 01", ErrCnt); end
            end
            if (n == 253) begin
                checks++; if (ErrCnt !== 8'hFE) begin failures++; $display("FAIL sat_fe: got %h want FE", ErrCnt); end
            end
            if (n == 254) begin
                checks++; if (ErrCnt !== 8'hFF) begin failures++; $display("FAIL sat_ff: got %h want FF", ErrCnt); end
            end
        end
        checks++; if (ErrCnt !== 8'hFF) begin failures++; $display("FAIL sat_hold: got %h want FF", ErrCnt); end
        checks++; if (CmdValid !== 1'b0) begin failures++; $display("FAIL sat_valid: got %b want 0", CmdValid); end
    endtask

    initial begin
        Rst    = 1'b1;
        RxDone = 1'b0;
        RxData = 8'h00;
        test_reset();
        test_basic_frame();
        test_wrap_and_bad_chk();
        test_noise();
        test_timeout();
        test_timeout_edges();
        test_back_to_back();
        test_reset_mid_and_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
